// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the multi-word carry-lookahead adder
// sequencer.
//   WORD_W  - width of one pass through the cla_64bit datapath
//   NWORDS  - number of passes per operation (operand = WORD_W*NWORDS bits)
//   state_t - sequencer states IDLE, RUN and DONE
package cla_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned NWORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_64bit.sv
// cla_64bit: 64-bit two-level carry-lookahead adder. Each 4-bit group forms
// its own generate/propagate terms, and the carry chain steps from group to
// group rather than from bit to bit.
// Ports:
//   a, b  in  64 - addends
//   cin   in   1 - carry into bit 0
//   sum   out 64 - a + b + cin, modulo 2^64
//   cout  out  1 - carry out of bit 63
module cla_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic [15:0] gg;
    logic [15:0] gp;
    logic [16:0] gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;

        for (int unsigned k = 0; k < 16; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end

        gc[0] = cin;
        for (int unsigned k = 0; k < 16; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end

        // Group carry feeds bit 0 of each group; bits 1..3 resolve locally.
        for (int unsigned k = 0; k < 16; k++) begin
            c[4*k] = gc[k];
            for (int unsigned j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end

        sum  = p ^ c;
        cout = gc[16];
    end

endmodule

// File: rtl/cla_mw_sched.sv
// cla_mw_sched: adds or subtracts WORD_W*NWORDS-bit operands by running a
// single cla_64bit over NWORDS passes, least-significant word first, and
// carrying between passes in a register.
// Ports:
//   CLK     in   1 - clock, rising edge
//   reset   in   1 - synchronous active-high reset
//   start   in   1 - begin an operation (accepted in IDLE only)
//   op_sub  in   1 - 0: A+B+cin, 1: A-B
//   in_a    in   W - operand A, captured with start
//   in_b    in   W - operand B, captured with start
//   cin     in   1 - carry-in for add, captured with start
//   busy    out  1 - operation in progress (RUN or DONE)
//   done    out  1 - one-cycle result-valid pulse
//   sum     out  W - result, held until the next accepted start
//   cout    out  1 - final carry; for subtract, 1 means no borrow
module cla_mw_sched #(
    parameter int unsigned WORD_W = cla_pkg::WORD_W,
    parameter int unsigned NWORDS = cla_pkg::NWORDS
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic [WORD_W*NWORDS-1:0] in_a,
    input  logic [WORD_W*NWORDS-1:0] in_b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [WORD_W*NWORDS-1:0] sum,
    output logic                     cout
);

    localparam int unsigned IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

    cla_pkg::state_t state;

    logic [WORD_W*NWORDS-1:0] a_q;
    logic [WORD_W*NWORDS-1:0] b_q;
    logic                     sub_q;
    logic                     carry;
    logic [IDX_W-1:0]         idx;

    logic [WORD_W-1:0] add_a;
    logic [WORD_W-1:0] add_b;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;

    // Subtract is A + ~B + 1: B is inverted per word here and the +1 comes
    // from the carry register being preset at start.
    always_comb begin
        add_a = a_q[idx*WORD_W +: WORD_W];
        add_b = b_q[idx*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};
    end

    cla_64bit u_cla (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= cla_pkg::IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                cla_pkg::IDLE: begin
                    if (start) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        sub_q <= op_sub;
                        carry <= op_sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= cla_pkg::RUN;
                    end
                end
                cla_pkg::RUN: begin
                    sum[idx*WORD_W +: WORD_W] <= add_sum;
                    carry <= add_cout;
                    if (idx == LAST) begin
                        state <= cla_pkg::DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                cla_pkg::DONE: begin
                    cout  <= carry;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= cla_pkg::IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= cla_pkg::IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_mw_sched.sv
// tb_cla_mw_sched: self-checking bench for cla_mw_sched. Directed cases plus
// a back-to-back random soak, all compared against a 257-bit arithmetic
// reference computed in the bench.
module tb_cla_mw_sched;

    localparam int unsigned W = 256;
    localparam int unsigned EXP_LAT = 5;

    logic         CLK = 1'b0;
    logic         reset;
    logic         start;
    logic         op_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    cla_mw_sched #(
        .WORD_W (64),
        .NWORDS (4)
    ) dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .op_sub (op_sub),
        .in_a   (in_a),
        .in_b   (in_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci, input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = '0;
            default: ;
        endcase
        return v;
    endfunction

    // Expects to be called between clock edges; returns one cycle after done
    // is seen, so a following call is accepted back-to-back.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub, input logic poke);
        logic [W:0] exp;
        int lat;
        int extra;
        exp    = ref_model(a, b, ci, sub);
        in_a   = a;
        in_b   = b;
        cin    = ci;
        op_sub = sub;
        start  = 1'b1;
        @(posedge CLK); #1;
        start  = 1'b0;
        in_a   = rand_word();
        in_b   = rand_word();
        cin    = ~ci;
        op_sub = ~sub;
        lat    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (poke && (k == 2 || k == 4)) begin
                in_a  = W'(9);
                in_b  = W'(9);
                start = 1'b1;
            end
        end
        check({tag, "_lat"}, (W+1)'(lat), (W+1)'(EXP_LAT));
        check({tag, "_res"}, {cout, sum}, exp);
        if (poke) begin
            extra = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge CLK); #1;
                if (done) extra++;
                check({tag, "_hold"}, {cout, sum}, exp);
            end
            check({tag, "_nodone2"}, (W+1)'(extra), '0);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        reset  = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        in_a   = '0;
        in_b   = '0;
        cin    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        check("rst_busy", (W+1)'(busy), '0);
        check("rst_done", (W+1)'(done), '0);
        check("rst_sum",  {cout, sum},  '0);

        // Accepted in the first cycle after reset.
        run_op("add_basic", W'(1), W'(2), 1'b1, 1'b0, 1'b0);
        run_op("ripple",    '1,    '0,    1'b1, 1'b0, 1'b0);
        run_op("sub_borrow", W'(5), W'(7), 1'b0, 1'b1, 1'b0);
        run_op("sub_ok",    W'(7), W'(5), 1'b1, 1'b1, 1'b0);
        run_op("busy_start", W'(100), W'(23), 1'b0, 1'b0, 1'b1);

        // Reset after pass 2 clears everything at once.
        in_a = '1; in_b = W'(3); cin = 1'b1; op_sub = 1'b0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        check("midrst_busy", (W+1)'(busy), '0);
        check("midrst_done", (W+1)'(done), '0);
        check("midrst_sum",  {cout, sum},  '0);
        run_op("after_rst", W'(40), W'(2), 1'b0, 1'b0, 1'b0);

        // Reset and start together: start is dropped.
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1; start = 1'b1; in_a = W'(11); in_b = W'(22);
        @(posedge CLK); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge CLK); #1;
        check("rst_start_busy", (W+1)'(busy), '0);
        check("rst_start_sum",  {cout, sum},  '0);

        for (int n = 0; n < 200; n++) begin
            ra = rand_word();
            rb = rand_word();
            rc = 1'($urandom);
            rs = 1'($urandom);
            run_op("soak", ra, rb, rc, rs, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cla_mw_sched.md
CLA_MW_SCHED -- requirements
Module: cla_mw_sched

Interface
REQ-001 Parameter WORD_W, default 64: width of one adder pass; fixed to the cla_64bit datapath width.
REQ-002 Parameter NWORDS, default 4: number of passes per operation; operand width is WORD_W*NWORDS (256).
REQ-003 CLK  input  1: the only clock; all state changes on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on rising CLK.
REQ-005 start  input  1: request a new operation; accepted only in IDLE.
REQ-006 op_sub  input  1: 0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored); captured with start.
REQ-007 in_a  input  256: operand A; captured with start.
REQ-008 in_b  input  256: operand B; captured with start.
REQ-009 cin  input  1: carry-in for add; captured with start.
REQ-010 busy  output  1: high while state is RUN or DONE.
REQ-011 done  output  1: one-cycle pulse, result valid.
REQ-012 sum  output  256: result; holds until the next accepted start.
REQ-013 cout  output  1: final carry-out; for subtract, 1 means no borrow (A >= B unsigned).

Function
REQ-014 The block shall time-share one cla_64bit instance across NWORDS passes, least-significant word first.
REQ-015 The FSM shall have the states IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> DONE after pass NWORDS-1.
- DONE -> IDLE unconditionally.
REQ-016 Start acceptance: in IDLE with start=1, the block shall latch in_a, in_b, op_sub and the carry register (cin, or 1 if op_sub), clear idx to 0 and clear sum.
REQ-017 RUN edge: the block shall write the adder's sum into word idx of sum, load the adder's cout into the carry register, and increment idx, with no wrap beyond NWORDS-1.
REQ-018 Adder inputs in RUN shall be A word idx, B word idx (bitwise inverted if op_sub), and the carry register.
REQ-019 Latency: done shall rise exactly NWORDS+1 cycles after the accepting edge (5 for the default), with cout equal to the carry register at that point.
REQ-020 start while busy shall be ignored, with no queueing; start in the DONE cycle shall also be ignored.
REQ-021 Back-to-back operation: start asserted in the cycle after done shall be accepted, giving a throughput of one operation per NWORDS+2 cycles.
REQ-022 Changes to in_a, in_b, cin or op_sub after acceptance shall not affect the running operation.
REQ-023 sum and cout shall hold their values from done until the next accepted start.

Reset
REQ-024 On reset=1 the block shall go to IDLE and clear busy, done, sum, cout, idx and the carry register, from any state including mid-RUN.
REQ-025 If reset and start are high in the same cycle, reset shall win and start shall be dropped.
REQ-026 In the first cycle after reset deasserts, the block shall accept start normally.

Structure
REQ-027 A shared package cla_pkg shall hold WORD_W, NWORDS and the state enumeration (IDLE, RUN, DONE).
REQ-028 The adder shall be a single sub-module instance of cla_64bit (a, b, cin, sum, cout), with no extra arithmetic in the sequencer.
REQ-029 idx shall be $clog2(NWORDS) bits wide.

Verification
REQ-030 Basic add: A=1, B=2, cin=1 -> done at edge +5, sum=4, cout=0.
REQ-031 Full carry ripple: A=all-ones(256), B=0, cin=1 -> sum=0, cout=1; carry must cross all 4 word boundaries.
REQ-032 Subtract with borrow: op_sub=1, A=5, B=7 -> sum=2^256-2 (all ones except LSB=0), cout=0; and A=7, B=5 -> sum=2, cout=1.
REQ-033 Start while busy: start re-pulsed with A=9, B=9 during RUN -> ignored; the first result completes unchanged and no second done appears.
REQ-034 Reset mid-operation: reset asserted on pass 2 -> next cycle busy=0, done=0, sum=0, cout=0; a new start afterwards gives a correct result.
REQ-035 Random soak: 200 random operations (random A, B, cin, op_sub) issued back-to-back -> each done matches the 257-bit reference {cout,sum} and arrives exactly 5 cycles after its start.
